// File: rtl/data_ram_dp.sv
// ---------------------------------------------------------------------------
// data_ram_dp
//   Dual-port data RAM: one synchronous write port and one independent read
//   port with a registered read result. DATA_W and DEPTH are configurable.
//   DEPTH does not have to be a power of two.
//   The read-during-write policy for a shared address is set by RDW_MODE:
//   0 returns the data being written, 1 returns the old contents.
//   With CLEAR_ON_RESET set, a sweep writes zero to every word after reset
//   is released. The sweep uses the normal write port through a mux.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   we      in   write request
//   waddr   in   write address   [ADDR_W]
//   wdata   in   write data      [DATA_W]
//   re      in   read request
//   raddr   in   read address    [ADDR_W]
//   rdata   out  registered read data [DATA_W]
//   rvalid  out  pulse: rdata holds the read accepted on the previous edge
//   busy    out  clear sweep in progress; requests are ignored
//   err     out  pulse: previous edge saw an out-of-range address on an
//                active port
// ---------------------------------------------------------------------------
module data_ram_dp #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // One extra bit, so that DEPTH == 2**ADDR_W can still be represented.
    localparam logic [ADDR_W:0]   DEPTH_X     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO   = ADDR_W'(0);
    localparam logic [DATA_W-1:0] DATA_ZERO   = DATA_W'(0);
    localparam logic [0:0]        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic              RESET_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

    // Storage. There is deliberately no reset here, so that the array can map
    // onto block RAM.
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [0:0]        state_r;
    logic [0:0]        next_state_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic [DATA_W-1:0] rdata_r;
    logic              rvalid_r;
    logic              busy_r;
    logic              err_r;

    logic              run_s;
    logic              waddr_ok_s;
    logic              raddr_ok_s;
    logic              wr_act_s;
    logic              rd_act_s;
    logic              err_nxt_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_data_s;

    assign run_s      = (state_r == ST_RUN);
    assign waddr_ok_s = ({1'b0, waddr} < DEPTH_X);
    assign raddr_ok_s = ({1'b0, raddr} < DEPTH_X);
    assign wr_act_s   = run_s & we & waddr_ok_s;
    // An out-of-range read is still accepted. It returns zero with rvalid.
    assign rd_act_s   = run_s & re;
    assign err_nxt_s  = run_s & ((we & ~waddr_ok_s) | (re & ~raddr_ok_s));

    // Sweep sequencing: step through CLEAR, then stay in RUN.
    always_comb begin
        next_state_s = state_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    next_state_s = ST_RUN;
                    cnt_nxt_s    = ADDR_ZERO;
                end else begin
                    next_state_s = ST_CLEAR;
                    cnt_nxt_s    = cnt_r + ADDR_ONE;
                end
            end
            ST_RUN: begin
                next_state_s = ST_RUN;
                cnt_nxt_s    = ADDR_ZERO;
            end
            default: begin
                next_state_s = RESET_STATE;
                cnt_nxt_s    = ADDR_ZERO;
            end
        endcase
    end

    // Write-port mux: the sweep owns the single write port while clearing.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = waddr;
        mem_wdata_s = wdata;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = DATA_ZERO;
        end else begin
            mem_we_s    = wr_act_s;
            mem_waddr_s = waddr;
            mem_wdata_s = wdata;
        end
    end

    // Read-data selection. Out-of-range reads return zero. In write-first
    // mode, a same-address write forwards wdata to the read result.
    always_comb begin
        rd_data_s = DATA_ZERO;
        if (!raddr_ok_s) begin
            rd_data_s = DATA_ZERO;
        end else if ((RDW_MODE == 0) && wr_act_s && (waddr == raddr)) begin
            rd_data_s = wdata;
        end else begin
            rd_data_s = mem_r[raddr];
        end
    end

    // Synchronous write port of the array.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RESET_STATE;
            cnt_r    <= ADDR_ZERO;
            busy_r   <= RESET_BUSY;
            rdata_r  <= DATA_ZERO;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= cnt_nxt_s;
            busy_r   <= (next_state_s == ST_CLEAR);
            rvalid_r <= rd_act_s;
            err_r    <= err_nxt_s;
            if (rd_act_s) begin
                rdata_r <= rd_data_s;
            end
        end
    end

    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
    assign busy   = busy_r;
    assign err    = err_r;

endmodule

// File: tb/tb_data_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_data_ram_dp
//   Three instances of data_ram_dp share one stimulus bus:
//     0: DEPTH=16, write-first
//     1: DEPTH=16, read-first
//     2: DEPTH=10 (ADDR_W=4), write-first
//   A behavioural model computes the expected outputs for every edge. The
//   expectations are queued before the edge and then popped and compared
//   after it.
// ---------------------------------------------------------------------------
module tb_data_ram_dp;

    localparam int ND = 3;

    typedef struct {
        logic [7:0] rdata;
        logic       rvalid;
        logic       err;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [3:0] raddr;

    logic [7:0] rdata_o  [ND];
    logic       rvalid_o [ND];
    logic       busy_o   [ND];
    logic       err_o    [ND];

    int         n_cmp;
    int         n_bad;
    exp_t       sbq [$];

    // Model state
    int         dep      [ND];
    int         rdw      [ND];
    int         clr_left [ND];
    logic [7:0] mdl      [ND][16];
    logic [7:0] last_rd  [ND];

    data_ram_dp #(.DATA_W(8), .DEPTH(16), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
        .busy(busy_o[0]), .err(err_o[0]));

    data_ram_dp #(.DATA_W(8), .DEPTH(16), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
        .busy(busy_o[1]), .err(err_o[1]));

    data_ram_dp #(.DATA_W(8), .DEPTH(10), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_o[2]), .rvalid(rvalid_o[2]),
        .busy(busy_o[2]), .err(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    // Assert reset, check the asynchronous reset values, then release rst_n
    // on the falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < ND; d++) begin
            chk("rst_rdata",  d, rdata_o[d], 8'h00);
            chk("rst_rvalid", d, {7'd0, rvalid_o[d]}, 8'h00);
            chk("rst_err",    d, {7'd0, err_o[d]}, 8'h00);
            chk("rst_busy",   d, {7'd0, busy_o[d]}, 8'h01);
            clr_left[d] = dep[d];
            last_rd[d]  = 8'h00;
            for (int a = 0; a < 16; a++) mdl[d][a] = 8'h00;
        end
        #2;
        rst_n = 1'b1;
    endtask

    // Drive one cycle of requests, queue the model's expectations, then
    // compare them with the DUT outputs after the edge.
    task automatic step(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                        input logic r, input logic [3:0] ra);
        exp_t e;
        logic wok;
        logic rok;
        we = w; waddr = wa; wdata = wd; re = r; raddr = ra;
        for (int d = 0; d < ND; d++) begin
            if (clr_left[d] > 0) begin
                clr_left[d]--;
                e.rdata  = last_rd[d];
                e.rvalid = 1'b0;
                e.err    = 1'b0;
                e.busy   = (clr_left[d] > 0);
            end else begin
                wok      = (int'(wa) < dep[d]);
                rok      = (int'(ra) < dep[d]);
                e.busy   = 1'b0;
                e.err    = (w && !wok) || (r && !rok);
                e.rvalid = r;
                if (r) begin
                    if (!rok)                                  last_rd[d] = 8'h00;
                    else if (w && (wa == ra) && (rdw[d] == 0)) last_rd[d] = wd;
                    else                                       last_rd[d] = mdl[d][ra];
                end
                e.rdata = last_rd[d];
                if (w && wok) mdl[d][wa] = wd;
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            e = sbq.pop_front();
            chk("rdata",  d, rdata_o[d], e.rdata);
            chk("rvalid", d, {7'd0, rvalid_o[d]}, {7'd0, e.rvalid});
            chk("err",    d, {7'd0, err_o[d]}, {7'd0, e.err});
            chk("busy",   d, {7'd0, busy_o[d]}, {7'd0, e.busy});
        end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        dep = '{16, 16, 10};
        rdw = '{0, 1, 0};
        rst_n = 1'b1; we = 1'b0; waddr = 4'd0; wdata = 8'h00; re = 1'b0; raddr = 4'd0;
        @(posedge clk); #1;
        do_reset();

        // Requests during the sweep are ignored. Busy is checked on each edge.
        for (int i = 0; i < 4; i++) step(1'b1, 4'd2, 8'h77, 1'b1, 4'd2);
        idle(12);
        idle(1);

        // After the sweep, every word reads as zero.
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd2);
        idle(1);

        // Basic write, then read.
        step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        idle(1);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
        idle(1);

        // Read-during-write at the same address.
        step(1'b1, 4'd7, 8'h11, 1'b0, 4'd0);
        step(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
        // Different addresses in the same cycle.
        step(1'b1, 4'd5, 8'h5A, 1'b1, 4'd3);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);

        // Out-of-range addresses (only for the DEPTH=10 instance).
        step(1'b1, 4'd12, 8'hFF, 1'b0, 4'd0);
        idle(1);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd12);
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
        idle(1);

        // Random mixed traffic.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        // A reset during a read drops the pending rvalid.
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        we = 1'b0; re = 1'b1; raddr = 4'd3;
        do_reset();
        re = 1'b0;

        // A reset in the middle of the sweep restarts it from address 0.
        idle(5);
        @(negedge clk);
        do_reset();
        idle(16);
        for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_ram_dp.md
Name: data_ram_dp

Overview:
Parametrised successor to the processor's 2-entry data RAM: one write port plus one independent read port, configurable width and depth. Read data is registered, with a read-valid flag. Read-during-write is selectable. An optional post-reset clear sweep zeroes the whole array. The block sits between the datapath load/store logic and the register file, replacing the fixed 8-bit x 2 store.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of words; any value >= 2, not necessarily a power of two
ADDR_W, $clog2(DEPTH), address width
RDW_MODE, 0, same-address read and write in one cycle: 0 = read returns new (written) data, 1 = read returns old data
CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no sweep, contents undefined after power-up

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
we  input  1  write request
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
re  input  1  read request
raddr  input  ADDR_W  read address
rdata  output  DATA_W  registered read data
rvalid  output  1  one-cycle pulse: rdata holds the result of the read accepted on the previous edge
busy  output  1  clear sweep in progress; requests are ignored
err  output  1  one-cycle pulse: previous edge saw an out-of-range address (>= DEPTH) on an active port

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata=0, rvalid=0, err=0.
  - busy=1 if CLEAR_ON_RESET, else 0.
  - Sweep counter=0.
  - Array contents are not reset directly.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR: each edge writes 0 to word[cnt] and increments cnt. The edge that writes word DEPTH-1 moves to RUN and drops busy. Sweep takes exactly DEPTH cycles after rst_n rises.
  - In CLEAR, we/re are ignored: no write, no rvalid, no err.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release.
- Reset asserted mid-read: the pending rvalid is lost and is not regenerated.
- RUN, write: on an edge with we=1 and waddr<DEPTH, word[waddr] <= wdata.
- RUN, read: on an edge with re=1 and raddr<DEPTH:
  - rdata <= word[raddr] and rvalid <= 1. Latency is 1 cycle.
  - Otherwise rvalid <= 0 and rdata holds its last value.
- Simultaneous we and re with waddr==raddr:
  - RDW_MODE=0: rdata <= wdata.
  - RDW_MODE=1: rdata <= the pre-write contents.
  - The write completes in both modes.
- Different addresses in the same cycle: fully independent.
- Out-of-range address (only possible when DEPTH is not a power of two):
  - Write: dropped, array unchanged.
  - Read: rdata <= 0, rvalid <= 1.
  - err <= 1 on the next edge if either active port is out of range; otherwise err <= 0.
- Back-to-back reads every cycle are allowed: rvalid stays high and rdata updates every cycle.
- Memory is a single inferred array with one synchronous write port and one registered read port, suitable for block RAM inference. The clear sweep shares the write port through a mux, not a second port.

Test Plan:
- Reset sweep (DEPTH=16, CLEAR_ON_RESET=1): release rst_n -> busy high for exactly 16 cycles, then low. Reading addresses 0..15 afterwards -> rdata=0x00 with rvalid each cycle.
- Basic write/read: write 0xA5 to address 3, then re at address 3 -> next edge rdata=0xA5, rvalid=1 for one cycle. Holding re with raddr=3,4 -> 0xA5 then 0x00.
- Read-during-write, same address 7 (old contents 0x11, wdata=0x3C): RDW_MODE=0 -> rdata=0x3C. RDW_MODE=1 -> rdata=0x11. A follow-up read -> 0x3C in both modes.
- Out of range (DEPTH=10, ADDR_W=4): write 0xFF to address 12 -> err pulse. Then read address 12 -> rdata=0x00, rvalid=1, err=1. Reading addresses 0..9 -> no word changed.
- Requests during sweep: assert we to address 2 with 0x77, plus re, during busy -> no rvalid, no err. After busy falls, read address 2 -> 0x00.
- Reset mid-sweep: pulse rst_n low 5 cycles into the sweep -> outputs reset immediately; busy stays high for a full 16 cycles after the second release.
